multicycle_controller: RTL and testbench

- Control FSM for the multicycle CPU; the producer side of the datapath control interface.
- Consumes the latched instruction (IReg_out) and the datapath Branch flag.
- Sequences each instruction through fetch/decode/execute/memory/writeback and drives every datapath control line.
- Moore machine: control outputs decode only from the current state and latched opcode, except PCWrite in BR_COMMIT.

---
 rtl/multicycle_controller_if.sv | 37 +++
 rtl/multicycle_controller.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// Datapath control bundle between the multicycle control FSM (master) and the datapath (slave).
// The master consumes IReg_out/Branch and drives every control line plus the debug/status outputs.
interface multicycle_controller_if;
  logic [31:0] IReg_out;
  logic        Branch;
  logic        PCWrite;
  logic        MemRead;
  logic        MemWrite;
  logic        IRWrite;
  logic        MemtoReg;
  logic        ALUSrcA;
  logic        RegWrite;
  logic        LUI;
  logic        SWB;
  logic [1:0]  PCSource;
  logic [1:0]  ALUSrcB;
  logic [2:0]  BranchType;
  logic [3:0]  ALUOp;
  logic [3:0]  state_dbg;
  logic        halted;
  logic        illegal;

  // No valid/ready handshake: the controller is a Moore sequencer and every control
  // line is meaningful in the cycle it is driven; IReg_out is stable from DECODE
  // until the next FETCH, and Branch is only consumed in BR_COMMIT.
  modport master (
    input  IReg_out, Branch,
    output PCWrite, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite, LUI, SWB,
           PCSource, ALUSrcB, BranchType, ALUOp, state_dbg, halted, illegal
  );

  modport slave (
    output IReg_out, Branch,
    input  PCWrite, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite, LUI, SWB,
           PCSource, ALUSrcB, BranchType, ALUOp, state_dbg, halted, illegal
  );
endinterface

// File: rtl/multicycle_controller.sv
// Control FSM of the multicycle CPU: walks each instruction through fetch/decode/execute/
// memory/writeback and drives all datapath control lines from state and latched opcode.
module multicycle_controller #(
    parameter logic [3:0] ALU_ADD   = 4'b0000,
    parameter logic [3:0] ALU_SUB   = 4'b0001,
    parameter logic [3:0] ALU_AND   = 4'b0010,
    parameter logic [3:0] ALU_OR    = 4'b0011,
    parameter logic [3:0] ALU_PASSB = 4'b1111
) (
    input  logic                        clk,
    input  logic                        reset,
    multicycle_controller_if.master     bus
);

    localparam logic [3:0] FETCH     = 4'd0;
    localparam logic [3:0] DECODE    = 4'd1;
    localparam logic [3:0] EXEC_R    = 4'd2;
    localparam logic [3:0] EXEC_I    = 4'd3;
    localparam logic [3:0] WB_ALU    = 4'd4;
    localparam logic [3:0] MEM_RD    = 4'd5;
    localparam logic [3:0] MEM_WB    = 4'd6;
    localparam logic [3:0] MEM_WR    = 4'd7;
    localparam logic [3:0] BR_EVAL   = 4'd8;
    localparam logic [3:0] BR_COMMIT = 4'd9;
    localparam logic [3:0] JUMP      = 4'd10;
    localparam logic [3:0] HALT      = 4'd11;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000001;
    localparam logic [5:0] OP_SUBI = 6'b000010;
    localparam logic [5:0] OP_ORI  = 6'b000011;
    localparam logic [5:0] OP_ANDI = 6'b000100;
    localparam logic [5:0] OP_LUI  = 6'b000101;
    localparam logic [5:0] OP_LW   = 6'b000110;
    localparam logic [5:0] OP_SW   = 6'b000111;
    localparam logic [5:0] OP_BEQ  = 6'b001000;
    localparam logic [5:0] OP_BNE  = 6'b001001;
    localparam logic [5:0] OP_BLT  = 6'b001010;
    localparam logic [5:0] OP_J    = 6'b001011;
    localparam logic [5:0] OP_HALT = 6'b111111;

    logic [3:0] state, state_next;
    logic [5:0] opcode;
    logic [3:0] funct;
    logic       is_r, is_imm, is_br, is_legal;
    logic [1:0] exec_srcb;
    logic [3:0] exec_op;
    logic [2:0] br_code;

    assign opcode = bus.IReg_out[31:26];
    assign funct  = bus.IReg_out[3:0];

    assign is_r     = (opcode == OP_R);
    assign is_imm   = (opcode >= OP_ADDI) && (opcode <= OP_LUI);
    assign is_br    = (opcode >= OP_BEQ) && (opcode <= OP_BLT);
    assign is_legal = (opcode <= OP_J) || (opcode == OP_HALT);

    // ALU setup shared by the execute state and the writeback state that holds it.
    always_comb begin
        exec_srcb = 2'b10;
        exec_op   = ALU_ADD;
        br_code   = 3'b000;
        if (is_r) begin
            exec_srcb = 2'b00;
            exec_op   = funct;
        end else begin
            case (opcode)
                OP_SUBI: exec_op = ALU_SUB;
                OP_ORI:  begin exec_srcb = 2'b11; exec_op = ALU_OR;    end
                OP_ANDI: begin exec_srcb = 2'b11; exec_op = ALU_AND;   end
                OP_LUI:  begin exec_srcb = 2'b11; exec_op = ALU_PASSB; end
                default: ;
            endcase
        end
        case (opcode)
            OP_BEQ:  br_code = 3'b001;
            OP_BNE:  br_code = 3'b010;
            OP_BLT:  br_code = 3'b011;
            default: br_code = 3'b000;
        endcase
    end

    always_comb begin
        state_next = FETCH;
        case (state)
            FETCH:   state_next = DECODE;
            DECODE: begin
                if (is_r)                  state_next = EXEC_R;
                else if (is_imm)           state_next = EXEC_I;
                else if (opcode == OP_LW)  state_next = MEM_RD;
                else if (opcode == OP_SW)  state_next = MEM_WR;
                else if (is_br)            state_next = BR_EVAL;
                else if (opcode == OP_J)   state_next = JUMP;
                else if (opcode == OP_HALT) state_next = HALT;
                else                       state_next = FETCH;
            end
            EXEC_R:  state_next = WB_ALU;
            EXEC_I:  state_next = WB_ALU;
            MEM_RD:  state_next = MEM_WB;
            BR_EVAL: state_next = BR_COMMIT;
            HALT:    state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_next;
    end

    // Reset gates every output so nothing strobes in the cycle reset is applied mid-instruction.
    always_comb begin
        bus.PCWrite    = 1'b0;
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.MemtoReg   = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.LUI        = 1'b0;
        bus.SWB        = 1'b0;
        bus.PCSource   = 2'b00;
        bus.ALUSrcB    = 2'b00;
        bus.BranchType = 3'b000;
        bus.ALUOp      = 4'b0000;
        bus.state_dbg  = 4'd0;
        bus.halted     = 1'b0;
        bus.illegal    = 1'b0;
        if (!reset) begin
            bus.state_dbg = state;
            case (state)
                FETCH: begin
                    bus.IRWrite = 1'b1;
                    bus.ALUSrcB = 2'b01;
                    bus.ALUOp   = ALU_ADD;
                    bus.PCWrite = 1'b1;
                end
                DECODE: begin
                    bus.SWB     = (opcode == OP_SW) || is_br;
                    bus.illegal = !is_legal;
                end
                EXEC_R, EXEC_I: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = exec_srcb;
                    bus.ALUOp   = exec_op;
                end
                WB_ALU: begin
                    bus.ALUSrcA  = 1'b1;
                    bus.ALUSrcB  = exec_srcb;
                    bus.ALUOp    = exec_op;
                    bus.RegWrite = 1'b1;
                    bus.LUI      = (opcode == OP_LUI);
                end
                MEM_RD: bus.MemRead = 1'b1;
                MEM_WB: begin
                    bus.MemRead  = 1'b1;
                    bus.MemtoReg = 1'b1;
                    bus.RegWrite = 1'b1;
                end
                MEM_WR: begin
                    bus.SWB      = 1'b1;
                    bus.MemWrite = 1'b1;
                end
                BR_EVAL: begin
                    bus.SWB        = 1'b1;
                    bus.BranchType = br_code;
                end
                BR_COMMIT: begin
                    bus.SWB        = 1'b1;
                    bus.BranchType = br_code;
                    bus.PCSource   = 2'b11;
                    bus.PCWrite    = bus.Branch;
                end
                JUMP: begin
                    bus.PCSource = 2'b10;
                    bus.PCWrite  = 1'b1;
                end
                HALT:    bus.halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expected control vectors are queued
// by the driver and checked at the falling edge by an independent monitor.
module tb_multicycle_controller;

  localparam int W = 26;

  // Strobe group bit order: PCWrite MemRead MemWrite IRWrite MemtoReg ALUSrcA RegWrite LUI SWB
  localparam logic [8:0] S_PCW  = 9'b100000000;
  localparam logic [8:0] S_MRD  = 9'b010000000;
  localparam logic [8:0] S_MWR  = 9'b001000000;
  localparam logic [8:0] S_IRW  = 9'b000100000;
  localparam logic [8:0] S_M2R  = 9'b000010000;
  localparam logic [8:0] S_SRCA = 9'b000001000;
  localparam logic [8:0] S_RW   = 9'b000000100;
  localparam logic [8:0] S_LUI  = 9'b000000010;
  localparam logic [8:0] S_SWB  = 9'b000000001;
  localparam logic [8:0] S_NONE = 9'b000000000;

  logic clk;
  logic reset;
  multicycle_controller_if bus();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [W-1:0] v(input logic [3:0] st, input logic [8:0] strobes,
                                     input logic [1:0] pcs, input logic [1:0] srcb,
                                     input logic [2:0] bt, input logic [3:0] op,
                                     input logic hl, input logic il);
    return {strobes, pcs, srcb, bt, op, st, hl, il};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic cyc(input logic [31:0] ir, input logic br, input logic rst, input logic [W-1:0] e);
    @(posedge clk);
    #1;
    bus.IReg_out = ir;
    bus.Branch   = br;
    reset        = rst;
    exp_q.push_back(e);
  endtask

  logic [W-1:0] e_zero, e_fetch, e_dec, e_dec_swb;
  initial begin
    e_zero    = v(4'd0, S_NONE, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0, 1'b0);
    e_fetch   = v(4'd0, S_IRW | S_PCW, 2'b00, 2'b01, 3'b000, 4'b0000, 1'b0, 1'b0);
    e_dec     = v(4'd1, S_NONE, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0, 1'b0);
    e_dec_swb = v(4'd1, S_SWB, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0, 1'b0);
  end

  task automatic run_r(input logic [31:0] ir, input logic [3:0] op);
    cyc(ir, 1'b0, 1'b0, e_fetch);
    cyc(ir, 1'b0, 1'b0, e_dec);
    cyc(ir, 1'b0, 1'b0, v(4'd2, S_SRCA, 2'b00, 2'b00, 3'b000, op, 1'b0, 1'b0));
    cyc(ir, 1'b0, 1'b0, v(4'd4, S_SRCA | S_RW, 2'b00, 2'b00, 3'b000, op, 1'b0, 1'b0));
  endtask

  task automatic run_imm(input logic [31:0] ir, input logic [1:0] srcb, input logic [3:0] op,
                         input logic is_lui);
    cyc(ir, 1'b0, 1'b0, e_fetch);
    cyc(ir, 1'b0, 1'b0, e_dec);
    cyc(ir, 1'b0, 1'b0, v(4'd3, S_SRCA, 2'b00, srcb, 3'b000, op, 1'b0, 1'b0));
    cyc(ir, 1'b0, 1'b0, v(4'd4, S_SRCA | S_RW | (is_lui ? S_LUI : S_NONE), 2'b00, srcb,
                          3'b000, op, 1'b0, 1'b0));
  endtask

  task automatic run_br(input logic [31:0] ir, input logic [2:0] bt, input logic taken);
    cyc(ir, 1'b0, 1'b0, e_fetch);
    cyc(ir, 1'b0, 1'b0, e_dec_swb);
    cyc(ir, 1'b0, 1'b0, v(4'd8, S_SWB, 2'b00, 2'b00, bt, 4'b0000, 1'b0, 1'b0));
    cyc(ir, taken, 1'b0, v(4'd9, S_SWB | (taken ? S_PCW : S_NONE), 2'b11, 2'b00, bt,
                           4'b0000, 1'b0, 1'b0));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] e;
    act = {bus.PCWrite, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.ALUSrcA,
           bus.RegWrite, bus.LUI, bus.SWB, bus.PCSource, bus.ALUSrcB, bus.BranchType,
           bus.ALUOp, bus.state_dbg, bus.halted, bus.illegal};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ctrl_vector", act, e);
      n_checks++;
      if (bus.MemRead === 1'b1 && bus.MemWrite === 1'b1) begin
        n_fail++;
        $display("FAIL inv_rd_wr: MemRead=%b MemWrite=%b required not both 1", bus.MemRead, bus.MemWrite);
      end
      n_checks++;
      if (bus.RegWrite === 1'b1 && bus.MemWrite === 1'b1) begin
        n_fail++;
        $display("FAIL inv_reg_mem: RegWrite=%b MemWrite=%b required not both 1", bus.RegWrite, bus.MemWrite);
      end
      n_checks++;
      if (bus.IRWrite === 1'b1 && bus.state_dbg !== 4'd0) begin
        n_fail++;
        $display("FAIL inv_irwrite: IRWrite=1 in state %0d required state 0", bus.state_dbg);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset        = 1'b1;
    bus.IReg_out = 32'h0;
    bus.Branch   = 1'b0;

    cyc(32'h0, 1'b0, 1'b1, e_zero);
    cyc(32'h0, 1'b0, 1'b1, e_zero);

    // R-type AND (funct 2)
    run_r(32'h00221802, 4'b0010);
    // R-type with funct 1 (SUB)
    run_r(32'h00000001, 4'b0001);

    // Immediate ops
    run_imm(32'h04000000, 2'b10, 4'b0000, 1'b0); // ADDI
    run_imm(32'h08000000, 2'b10, 4'b0001, 1'b0); // SUBI
    run_imm(32'h0C000000, 2'b11, 4'b0011, 1'b0); // ORI
    run_imm(32'h10000000, 2'b11, 4'b0010, 1'b0); // ANDI
    run_imm(32'h14000000, 2'b11, 4'b1111, 1'b1); // LUI

    // LW
    cyc(32'h18200010, 1'b0, 1'b0, e_fetch);
    cyc(32'h18200010, 1'b0, 1'b0, e_dec);
    cyc(32'h18200010, 1'b0, 1'b0, v(4'd5, S_MRD, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0, 1'b0));
    cyc(32'h18200010, 1'b0, 1'b0, v(4'd6, S_MRD | S_M2R | S_RW, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0, 1'b0));

    // SW
    cyc(32'h1C200010, 1'b0, 1'b0, e_fetch);
    cyc(32'h1C200010, 1'b0, 1'b0, e_dec_swb);
    cyc(32'h1C200010, 1'b0, 1'b0, v(4'd7, S_SWB | S_MWR, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0, 1'b0));

    // Branches
    run_br(32'h20220005, 3'b001, 1'b1); // BEQ taken
    run_br(32'h20220005, 3'b001, 1'b0); // BEQ not taken
    run_br(32'h24000000, 3'b010, 1'b1); // BNE taken
    run_br(32'h28000000, 3'b011, 1'b0); // BLT not taken

    // J
    cyc(32'h2C000000, 1'b0, 1'b0, e_fetch);
    cyc(32'h2C000000, 1'b0, 1'b0, e_dec);
    cyc(32'h2C000000, 1'b0, 1'b0, v(4'd10, S_PCW, 2'b10, 2'b00, 3'b000, 4'b0000, 1'b0, 1'b0));

    // Undefined opcode 0x3E: one illegal pulse, straight back to FETCH
    cyc(32'hF8000000, 1'b0, 1'b0, e_fetch);
    cyc(32'hF8000000, 1'b0, 1'b0, v(4'd1, S_NONE, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0, 1'b1));
    // Undefined opcode 0x0C
    cyc(32'h30000000, 1'b0, 1'b0, e_fetch);
    cyc(32'h30000000, 1'b0, 1'b0, v(4'd1, S_NONE, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0, 1'b1));

    // Reset in MEM_WR
    cyc(32'h1C200010, 1'b0, 1'b0, e_fetch);
    cyc(32'h1C200010, 1'b0, 1'b0, e_dec_swb);
    cyc(32'h1C200010, 1'b0, 1'b1, e_zero);
    // Reset in WB_ALU
    cyc(32'h00221802, 1'b0, 1'b0, e_fetch);
    cyc(32'h00221802, 1'b0, 1'b0, e_dec);
    cyc(32'h00221802, 1'b0, 1'b0, v(4'd2, S_SRCA, 2'b00, 2'b00, 3'b000, 4'b0010, 1'b0, 1'b0));
    cyc(32'h00221802, 1'b0, 1'b1, e_zero);

    // HALT held 20 cycles, then reset
    cyc(32'hFC000000, 1'b0, 1'b0, e_fetch);
    cyc(32'hFC000000, 1'b0, 1'b0, e_dec);
    for (int i = 0; i < 20; i++)
      cyc(32'hFC000000, 1'b0, 1'b0, v(4'd11, S_NONE, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b1, 1'b0));
    cyc(32'hFC000000, 1'b0, 1'b1, e_zero);

    // Normal operation after recovery
    run_r(32'h00000003, 4'b0011);

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d entries left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
